// File: rtl/hero_arb_pkg.sv
// Shared types and constants for the hero bus arbiter.
// Re-exports the hero beat type so arbiter users need only this package.
package hero_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } ARB_STATE_E;

    localparam int HERO_ARB_MAX_REQ = 16;

    typedef test_pkg_a::hero_write_t hero_write_t;
    typedef test_pkg_a::cycle_type_e cycle_type_e;

    localparam int HERO_WRITE_T_WIDTH = $bits(test_pkg_a::hero_write_t);

    localparam cycle_type_e CYCLE_TYPE_IDLE  = test_pkg_a::CYCLE_TYPE_IDLE;
    localparam cycle_type_e CYCLE_TYPE_VALID = test_pkg_a::CYCLE_TYPE_VALID;
    localparam cycle_type_e CYCLE_TYPE_DONE  = test_pkg_a::CYCLE_TYPE_DONE;

    // Terminating beat injected when a stalled owner is forcibly released.
    function automatic hero_write_t hero_synth_done();
        hero_write_t beat;
        beat            = '0;
        beat.cycle_type = CYCLE_TYPE_DONE;
        return beat;
    endfunction

endpackage

// File: rtl/test_pkg_a.sv
// Hero write bus beat definition shared by hero producers and sinks.
// A beat is 46 bits: cycle type, clock-enable flag, address and write data.
package test_pkg_a;

    typedef enum logic [1:0] {
        CYCLE_TYPE_IDLE  = 2'd0,
        CYCLE_TYPE_VALID = 2'd1,
        CYCLE_TYPE_DONE  = 2'd2,
        CYCLE_TYPE_RSVD  = 2'd3
    } cycle_type_e;

    typedef struct packed {
        cycle_type_e cycle_type;
        logic        clk_en;
        logic [10:0] addr;
        logic [31:0] wdat;
    } hero_write_t;

endpackage

// File: rtl/hero_arb_if.sv
// Bus bundle between hero requesters, the arbiter and the hero sink.
// slave: arbiter side; master: requester/sink side.
interface hero_arb_if
    import hero_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    hero_write_t [NUM_REQ-1:0] req_hero_i;
    logic        [NUM_REQ-1:0] req_ready_o;
    hero_write_t               hero_o;
    logic                      hero_ready_i;
    logic                      lock_o;
    logic        [IDX_W-1:0]   owner_o;
    logic                      timeout_o;

    modport slave (
        input  req_hero_i,
        input  hero_ready_i,
        output req_ready_o,
        output hero_o,
        output lock_o,
        output owner_o,
        output timeout_o
    );

    modport master (
        output req_hero_i,
        output hero_ready_i,
        input  req_ready_o,
        input  hero_o,
        input  lock_o,
        input  owner_o,
        input  timeout_o
    );

endinterface

// File: rtl/hero_rr_picker.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping around; returns one-hot grant, its index and a hit flag.
module hero_rr_picker
    import hero_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    int w_cand;

    if (NUM_REQ < 2 || NUM_REQ > HERO_ARB_MAX_REQ) begin : g_bad_num_req
        $error("hero_rr_picker: NUM_REQ out of range");
    end

    // Scan requesters starting at the pointer; the first hit wins
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = int'(i_rr_ptr) + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end else begin
                w_cand = w_cand;
            end
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_idx           = w_cand[IDX_W-1:0];
                o_grant[w_cand] = 1'b1;
            end else begin
                o_any = o_any;
            end
        end
    end

endmodule

// File: rtl/hero_bus_arbiter.sv
// Round-robin arbiter sharing one hero write bus among NUM_REQ requesters.
// Whole transactions (VALID* then DONE) are granted without interleaving;
// the output beat is registered and honours sink backpressure.
// Optional feature macro: HERO_ARB_TIMEOUT_EN (forced release of an owner
// that stays idle for TIMEOUT_CYC free cycles while holding the lock).
module hero_bus_arbiter
    import hero_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    hero_arb_if.slave  bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("hero_bus_arbiter: TIMEOUT_CYC must be at least 1");
    end

    logic [NUM_REQ-1:0] w_req_vld;
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_own_oh;
    logic [NUM_REQ-1:0] w_ready;
    logic [IDX_W-1:0]   w_pick_idx;
    logic [IDX_W-1:0]   w_sel_idx;
    logic [IDX_W-1:0]   w_next_rr;
    logic               w_pick_any;
    logic               w_out_free;
    logic               w_sel_vld;
    logic               w_sel_done;
    logic               w_accept;
    logic               w_tmo_hit;
    hero_write_t        w_sel_beat;

    ARB_STATE_E         r_state;
    hero_write_t        r_hero;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_rr_ptr;

    hero_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_req    (w_req_vld),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_grant),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    // A requester is asking for the bus whenever its beat is not IDLE
    always_comb begin
        w_req_vld = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_req_vld[i] = (bus.req_hero_i[i].cycle_type != CYCLE_TYPE_IDLE);
        end
    end

    // Choose the requester served this cycle and decide whether its beat is taken
    always_comb begin
        w_out_free         = (r_hero.cycle_type == CYCLE_TYPE_IDLE) | bus.hero_ready_i;
        w_own_oh           = '0;
        w_own_oh[r_owner]  = 1'b1;
        if (r_state == ARB_LOCK) begin
            w_sel_idx = r_owner;
            w_ready   = w_own_oh & {NUM_REQ{w_out_free}};
        end else begin
            w_sel_idx = w_pick_idx;
            w_ready   = w_grant & {NUM_REQ{w_out_free}};
        end
        w_sel_beat = bus.req_hero_i[w_sel_idx];
        w_sel_vld  = w_req_vld[w_sel_idx];
        w_sel_done = (w_sel_beat.cycle_type == CYCLE_TYPE_DONE);
        if (r_state == ARB_LOCK) begin
            w_accept = w_out_free & w_sel_vld;
        end else begin
            w_accept = w_out_free & w_pick_any;
        end
        if (w_sel_idx == IDX_W'(NUM_REQ - 1)) begin
            w_next_rr = {IDX_W{1'b0}};
        end else begin
            w_next_rr = w_sel_idx + IDX_W'(1);
        end
    end

`ifdef HERO_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_timeout;

    // Forced release fires on the free idle cycle that reaches the limit
    always_comb begin
        w_tmo_hit = (r_state == ARB_LOCK) & ~w_sel_vld & w_out_free &
                    (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    end

    // Count free cycles in which the lock owner presents nothing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (r_state != ARB_LOCK) begin
            r_tmo_cnt <= '0;
        end else if (w_sel_vld) begin
            r_tmo_cnt <= '0;
        end else if (!w_out_free) begin
            r_tmo_cnt <= r_tmo_cnt;
        end else if (w_tmo_hit) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    assign bus.timeout_o = r_timeout;
`else
    assign w_tmo_hit     = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif

    // Arbitration FSM, output beat register, owner and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ARB_IDLE;
            r_hero   <= '0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
`ifdef HERO_ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
        end else begin
`ifdef HERO_ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            if (w_out_free) begin
                if (w_accept) begin
                    r_hero <= w_sel_beat;
                end else if (w_tmo_hit) begin
                    r_hero <= hero_synth_done();
                end else begin
                    r_hero <= '0;
                end
                case (r_state)
                    ARB_IDLE: begin
                        if (w_accept) begin
                            r_owner <= w_sel_idx;
                            if (w_sel_done) begin
                                r_rr_ptr <= w_next_rr;
                            end else begin
                                r_state <= ARB_LOCK;
                            end
                        end else begin
                            r_state <= ARB_IDLE;
                        end
                    end
                    ARB_LOCK: begin
                        if (w_accept && w_sel_done) begin
                            r_state  <= ARB_IDLE;
                            r_rr_ptr <= w_next_rr;
                        end else if (w_tmo_hit) begin
                            r_state  <= ARB_IDLE;
                            r_rr_ptr <= w_next_rr;
`ifdef HERO_ARB_TIMEOUT_EN
                            r_timeout <= 1'b1;
`endif
                        end else begin
                            r_state <= ARB_LOCK;
                        end
                    end
                    default: begin
                        r_state <= ARB_IDLE;
                    end
                endcase
            end else begin
                r_hero <= r_hero;
            end
        end
    end

    assign bus.req_ready_o = w_ready;
    assign bus.hero_o      = r_hero;
    assign bus.lock_o      = (r_state == ARB_LOCK);
    assign bus.owner_o     = r_owner;

endmodule

// File: tb/tb_hero_bus_arbiter.sv
// Self-checking bench for hero_bus_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level reference model.
module tb_hero_bus_arbiter;
    import hero_arb_pkg::*;

    localparam int N = 4;
`ifdef HERO_ARB_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 64;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    hero_arb_if #(.NUM_REQ(N)) bus ();

    hero_bus_arbiter #(
        .NUM_REQ     (N),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    hero_write_t    m_hero;
    int             m_owner = -1;   // -1: bus not locked
    int             m_last  = 0;
    int             m_rr    = 0;
    int             m_idle  = 0;
    bit             m_tmo   = 1'b0;
    logic [N-1:0]   m_acc   = '0;

    always @(negedge clk) begin : model
        int           win;
        int           j;
        bit           free;
        logic [N-1:0] exp_rdy;
        hero_write_t  syn;
        if (!rst_n) begin
            chk("rst_hero",  bus.hero_o,      64'd0);
            chk("rst_ready", bus.req_ready_o, 64'd0);
            chk("rst_lock",  bus.lock_o,      64'd0);
            chk("rst_owner", bus.owner_o,     64'd0);
            chk("rst_tmo",   bus.timeout_o,   64'd0);
            m_hero  = '0;
            m_owner = -1;
            m_last  = 0;
            m_rr    = 0;
            m_idle  = 0;
            m_tmo   = 1'b0;
            m_acc   = '0;
        end else begin
            free = (m_hero.cycle_type == CYCLE_TYPE_IDLE) || (bus.hero_ready_i == 1'b1);
            win  = -1;
            if (m_owner >= 0) begin
                win = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    j = (m_rr + k) % N;
                    if (win < 0 && bus.req_hero_i[j].cycle_type != CYCLE_TYPE_IDLE) win = j;
                end
            end
            exp_rdy = '0;
            if (win >= 0) exp_rdy[win] = free;

            chk("m_hero",  bus.hero_o,      m_hero);
            chk("m_ready", bus.req_ready_o, exp_rdy);
            chk("m_lock",  bus.lock_o,      (m_owner >= 0));
            chk("m_owner", bus.owner_o,     64'(m_last));
            chk("m_tmo",   bus.timeout_o,   m_tmo);

            m_acc = '0;
            m_tmo = 1'b0;
            if (m_owner >= 0 && bus.req_hero_i[m_owner].cycle_type != CYCLE_TYPE_IDLE) m_idle = 0;
            if (free) begin
                if (win >= 0 && bus.req_hero_i[win].cycle_type != CYCLE_TYPE_IDLE) begin
                    m_acc[win] = 1'b1;
                    m_hero     = bus.req_hero_i[win];
                    m_last     = win;
                    m_idle     = 0;
                    if (bus.req_hero_i[win].cycle_type == CYCLE_TYPE_DONE) begin
                        m_owner = -1;
                        m_rr    = (win + 1) % N;
                    end else begin
                        m_owner = win;
                    end
                end else begin
                    m_hero = '0;
`ifdef HERO_ARB_TIMEOUT_EN
                    if (m_owner >= 0) begin
                        m_idle++;
                        if (m_idle == TMO) begin
                            syn            = '0;
                            syn.cycle_type = CYCLE_TYPE_DONE;
                            m_hero         = syn;
                            m_tmo          = 1'b1;
                            m_rr           = (m_owner + 1) % N;
                            m_owner        = -1;
                            m_idle         = 0;
                        end
                    end
`endif
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int i, input cycle_type_e ct, input logic [31:0] wd);
        hero_write_t b;
        b                 = '0;
        b.cycle_type      = ct;
        b.wdat            = wd;
        bus.req_hero_i[i] = b;
    endtask

    task automatic all_idle();
        for (int i = 0; i < N; i++) bus.req_hero_i[i] = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        all_idle();
        bus.hero_ready_i = 1'b1;
        step();
        chk("rst_lit_ready", bus.req_ready_o, 64'd0);
        chk("rst_lit_lock",  bus.lock_o,      64'd0);
        rst_n = 1'b1;
    endtask

    task automatic rand_phase(input int cycles);
        int          rem[N];
        bit          in_txn[N];
        bit          pres[N];
        hero_write_t cur[N];
        bit          tail;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; in_txn[i] = 1'b0; pres[i] = 1'b0; cur[i] = '0;
        end
        for (int c = 0; c < cycles + 100; c++) begin
            step();
            tail = (c >= cycles);
            for (int i = 0; i < N; i++) begin
                if (m_acc[i]) begin
                    if (cur[i].cycle_type == CYCLE_TYPE_DONE) in_txn[i] = 1'b0;
                    else rem[i]--;
                    pres[i] = 1'b0;
                end
                if (!pres[i]) begin
                    if (in_txn[i]) begin
                        if (tail || $urandom_range(0, 3) != 0) pres[i] = 1'b1;
                    end else if (!tail && $urandom_range(0, 2) == 0) begin
                        in_txn[i] = 1'b1;
                        rem[i]    = $urandom_range(0, 3);
                        pres[i]   = 1'b1;
                    end
                    if (pres[i]) begin
                        cur[i].cycle_type = (rem[i] > 0) ? CYCLE_TYPE_VALID : CYCLE_TYPE_DONE;
                        cur[i].clk_en     = 1'($urandom);
                        cur[i].addr       = 11'($urandom);
                        cur[i].wdat       = $urandom;
                    end
                end
                bus.req_hero_i[i] = pres[i] ? cur[i] : hero_write_t'('0);
            end
            bus.hero_ready_i = tail ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
        all_idle();
        step();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        all_idle();
        bus.hero_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single requester, VALID,VALID,DONE
        set_req(0, CYCLE_TYPE_VALID, 32'h1);
        step();
        chk("t1_b1_wdat", bus.hero_o.wdat, 64'h1);
        chk("t1_b1_type", bus.hero_o.cycle_type, 64'(CYCLE_TYPE_VALID));
        chk("t1_b1_lock", bus.lock_o, 64'd1);
        set_req(0, CYCLE_TYPE_VALID, 32'h2);
        step();
        chk("t1_b2_wdat", bus.hero_o.wdat, 64'h2);
        chk("t1_b2_lock", bus.lock_o, 64'd1);
        set_req(0, CYCLE_TYPE_DONE, 32'h3);
        step();
        chk("t1_b3_wdat", bus.hero_o.wdat, 64'h3);
        chk("t1_b3_type", bus.hero_o.cycle_type, 64'(CYCLE_TYPE_DONE));
        chk("t1_b3_lock", bus.lock_o, 64'd0);
        all_idle();
        step();
        chk("t1_drain", bus.hero_o.cycle_type, 64'(CYCLE_TYPE_IDLE));

        // four simultaneous single-beat requests from reset
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, CYCLE_TYPE_DONE, 32'h10 + 32'(i));
        for (int k = 0; k < N; k++) begin
            step();
            chk("t2_owner", bus.owner_o, 64'(k));
            chk("t2_wdat",  bus.hero_o.wdat, 64'(32'h10 + 32'(k)));
            set_req(k, CYCLE_TYPE_IDLE, 32'h0);
        end
        set_req(3, CYCLE_TYPE_DONE, 32'h40);
        set_req(0, CYCLE_TYPE_DONE, 32'h41);
        step();
        chk("t2_wrap_owner", bus.owner_o, 64'd0);
        chk("t2_wrap_wdat",  bus.hero_o.wdat, 64'h41);
        set_req(0, CYCLE_TYPE_IDLE, 32'h0);
        step();
        chk("t2_last_owner", bus.owner_o, 64'd3);
        all_idle();
        step();

        // sink stall holds the beat
        set_req(0, CYCLE_TYPE_VALID, 32'hA);
        step();
        chk("t4_first", bus.hero_o.wdat, 64'hA);
        bus.hero_ready_i = 1'b0;
        set_req(0, CYCLE_TYPE_DONE, 32'hB);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t4_hold_wdat", bus.hero_o.wdat, 64'hA);
            chk("t4_hold_rdy",  bus.req_ready_o, 64'd0);
        end
        bus.hero_ready_i = 1'b1;
        step();
        chk("t4_resume_wdat", bus.hero_o.wdat, 64'hB);
        chk("t4_resume_lock", bus.lock_o, 64'd0);
        all_idle();
        step();

        // locked owner blocks a competitor until its DONE
        set_req(1, CYCLE_TYPE_VALID, 32'h21);
        step();
        chk("t3_owner", bus.owner_o, 64'd1);
        set_req(1, CYCLE_TYPE_IDLE, 32'h0);
        set_req(2, CYCLE_TYPE_DONE, 32'h31);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("t3_blocked", bus.req_ready_o[2], 64'd0);
            chk("t3_lock",    bus.lock_o, 64'd1);
        end
        set_req(1, CYCLE_TYPE_DONE, 32'h22);
        step();
        chk("t3_done_wdat", bus.hero_o.wdat, 64'h22);
        set_req(1, CYCLE_TYPE_IDLE, 32'h0);
        step();
        chk("t3_next_wdat",  bus.hero_o.wdat, 64'h31);
        chk("t3_next_owner", bus.owner_o, 64'd2);
        all_idle();
        step();

`ifdef HERO_ARB_TIMEOUT_EN
        // stalled owner is released after TMO idle cycles
        do_reset();
        set_req(3, CYCLE_TYPE_VALID, 32'h55);
        step();
        set_req(3, CYCLE_TYPE_IDLE, 32'h0);
        for (int k = 0; k < TMO - 1; k++) begin
            step();
            chk("t5_wait_lock", bus.lock_o, 64'd1);
            chk("t5_wait_tmo",  bus.timeout_o, 64'd0);
        end
        step();
        chk("t5_type", bus.hero_o.cycle_type, 64'(CYCLE_TYPE_DONE));
        chk("t5_wdat", bus.hero_o.wdat, 64'd0);
        chk("t5_tmo",  bus.timeout_o, 64'd1);
        chk("t5_lock", bus.lock_o, 64'd0);
        step();
        chk("t5_tmo_end", bus.timeout_o, 64'd0);
`endif

        // asynchronous reset while locked
        do_reset();
        set_req(2, CYCLE_TYPE_VALID, 32'h66);
        step();
        chk("t6_locked", bus.lock_o, 64'd1);
        #2;
        rst_n = 1'b0;
        all_idle();
        #1;
        chk("t6_async_lock",  bus.lock_o, 64'd0);
        chk("t6_async_hero",  bus.hero_o, 64'd0);
        chk("t6_async_owner", bus.owner_o, 64'd0);
        step();
        rst_n = 1'b1;
        set_req(1, CYCLE_TYPE_DONE, 32'h71);
        set_req(3, CYCLE_TYPE_DONE, 32'h73);
        step();
        chk("t6_fresh_owner", bus.owner_o, 64'd1);
        set_req(1, CYCLE_TYPE_IDLE, 32'h0);
        step();
        chk("t6_second_owner", bus.owner_o, 64'd3);
        all_idle();
        step();

        // randomized traffic against the model
        rand_phase(2500);
        do_reset();
        rand_phase(1500);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
